// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
// Shares one combinational WIDTH-bit multiplier between two requesters.
// A winner is chosen in IDLE (round-robin when both ask). Its operands are
// registered onto mul_a/mul_b and held for SETTLE_CYCLES edges. The low WIDTH
// bits of the product are then captured into result, with a one-cycle done
// pulse to the winner. A one-cycle DONE turnaround follows before the next
// arbitration.
//
// Handshake: reqN is a level. The requester holds reqN and keeps aN/bN stable
// until it sees gntN (a one-cycle pulse meaning the operands were latched).
// After that the operands may change. reqN stays high until doneN (a one-cycle
// pulse meaning result is valid for N), and must fall in the following cycle
// unless another operation is wanted. A req still high during the turnaround
// cycle is only looked at again once the controller is back in IDLE.
//
// SETTLE_CYCLES must lie in 1..15; the settle counter is 4 bits wide.

module mul_share_ctrl #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_product,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;

    // cnt counts the edges the operands have still to sit on the multiplier.
    logic [3:0] cnt;

    // rr_ptr names the requester that wins a tie; it points away from the
    // requester served most recently and returns to 0 on reset.
    logic       rr_ptr;

    // owner remembers which requester the in-flight operation belongs to.
    logic       owner;

    // Decoded actions for the current cycle.
    logic       take;     // start an operation at this edge
    logic       pick1;    // the operation being started belongs to requester 1
    logic       capture;  // sample the product at this edge

    assign state_dbg = state;

    // Arbitration: a lone requester wins; on a tie rr_ptr decides.
    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0) begin
            pick1 = 1'b1;
        end else if (req1 && req0) begin
            pick1 = rr_ptr;
        end
    end

    // Next-state and action decode.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    take      = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Settle counter: loaded on a grant, counts down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (take) begin
            cnt <= SETTLE_INIT;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Operand registers feeding the multiplier; they hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (take) begin
            mul_a <= pick1 ? a1 : a0;
            mul_b <= pick1 ? b1 : b0;
        end
    end

    // Owner of the in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
        end else if (take) begin
            owner <= pick1;
        end
    end

    // Grant pulses: high only for the cycle after the operands are latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
        end else begin
            gnt0 <= take && !pick1;
            gnt1 <= take && pick1;
        end
    end

    // Product capture and done pulses; result holds until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            done0 <= capture && !owner;
            done1 <= capture && owner;
            if (capture) begin
                result <= mul_product;
            end
        end
    end

    // Round-robin pointer moves away from the requester just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (capture) begin
            rr_ptr <= ~owner;
        end
    end

    // busy covers grant through the capture edge; it drops on the turnaround edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (take) begin
            busy <= 1'b1;
        end else if (state == ST_DONE) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl
// Bench for mul_share_ctrl: directed scenarios with literal expectations,
// randomized traffic checked every cycle against a schedule-based model,
// and a settle-time-3 sweep on a second instance.

module tb_mul_share_ctrl;

    localparam int W  = 64;
    localparam int S  = 2;
    localparam int S3 = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst3_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (SETTLE_CYCLES = 2) ----------------
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, done0, done1, busy;
    logic [W-1:0] result, mul_a, mul_b, mul_product;
    logic [1:0]   state_dbg;

    assign mul_product = mul_a * mul_b;

    mul_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .state_dbg(state_dbg)
    );

    // ---------------- sweep instance (SETTLE_CYCLES = 3) ----------------
    logic         sreq0 = 1'b0;
    logic         sreq1 = 1'b0;
    logic [W-1:0] sa0 = '0, sb0 = '0, sa1 = '0, sb1 = '0;
    logic         gnt0_3, gnt1_3, done0_3, done1_3, busy_3;
    logic [W-1:0] result_3, mul_a_3, mul_b_3, mul_product_3;
    logic [1:0]   state_dbg_3;

    assign mul_product_3 = mul_a_3 * mul_b_3;

    mul_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req0(sreq0), .a0(sa0), .b0(sb0),
        .req1(sreq1), .a1(sa1), .b1(sb1),
        .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3),
        .result(result_3), .busy(busy_3),
        .mul_a(mul_a_3), .mul_b(mul_b_3), .mul_product(mul_product_3),
        .state_dbg(state_dbg_3)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Operations are tracked as a schedule of edge numbers: a grant at edge n
    // completes at edge n+S, busy drops at n+S+1, and the next grant can
    // happen no earlier than edge n+S+2.
    logic         m_gnt0, m_gnt1, m_done0, m_done1, m_busy;
    logic [W-1:0] m_result, m_mul_a, m_mul_b;
    bit           m_fav, m_owner, m_active;
    longint       m_edge, m_done_edge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done0 = 1'b0; m_done1 = 1'b0;
            m_busy = 1'b0; m_result = '0; m_mul_a = '0; m_mul_b = '0;
            m_fav = 1'b0; m_owner = 1'b0; m_active = 1'b0;
            m_edge = 0; m_done_edge = 0;
        end else begin
            m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done0 = 1'b0; m_done1 = 1'b0;
            if (m_active) begin
                if (m_edge == m_done_edge) begin
                    m_result = m_mul_a * m_mul_b;
                    if (m_owner) m_done1 = 1'b1;
                    else         m_done0 = 1'b1;
                    m_fav = ~m_owner;
                end else if (m_edge == m_done_edge + 1) begin
                    m_busy   = 1'b0;
                    m_active = 1'b0;
                end
            end else if (req0 || req1) begin
                m_owner = (req0 && req1) ? m_fav : req1;
                m_mul_a = m_owner ? a1 : a0;
                m_mul_b = m_owner ? b1 : b0;
                if (m_owner) m_gnt1 = 1'b1;
                else         m_gnt0 = 1'b1;
                m_busy      = 1'b1;
                m_active    = 1'b1;
                m_done_edge = m_edge + S;
            end
            m_edge++;
        end
    end

    // Compare the main instance against the model on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt0",   W'(gnt0),  W'(m_gnt0));
            chk("gnt1",   W'(gnt1),  W'(m_gnt1));
            chk("done0",  W'(done0), W'(m_done0));
            chk("done1",  W'(done1), W'(m_done1));
            chk("busy",   W'(busy),  W'(m_busy));
            chk("result", result,    m_result);
            chk("mul_a",  mul_a,     m_mul_a);
            chk("mul_b",  mul_b,     m_mul_b);
            chk("gnt_excl",  W'(gnt0 & gnt1),   '0);
            chk("done_excl", W'(done0 & done1), '0);
        end
    end

    // ---------------- driver tasks ----------------
    // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 either gnt. k = edges waited, 0 on timeout.
    task automatic wait_for(input int sel, input int budget, output int k);
        k = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((sel == 0 && gnt0) || (sel == 1 && gnt1) ||
                (sel == 2 && done0) || (sel == 3 && done1) ||
                (sel == 4 && (gnt0 || gnt1))) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k == 0) begin
            n_fail++;
            $display("FAIL wait_%0d: no event within %0d cycles", sel, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- random requesters ----------------
    bit rand_phase  = 1'b0;
    bit r0_granted  = 1'b0;
    bit r1_granted  = 1'b0;

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) v = W'($urandom_range(0, 20));
        if ($urandom_range(0, 7) == 0) v = -W'($urandom_range(1, 20));
        return v;
    endfunction

    always @(negedge clk) begin
        if (rand_phase) begin
            if (!req0) begin
                if ($urandom_range(0, 3) == 0) begin
                    req0 = 1'b1; a0 = rand_op(); b0 = rand_op(); r0_granted = 1'b0;
                end
            end else begin
                if (gnt0) r0_granted = 1'b1;
                if (done0) begin
                    r0_granted = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin a0 = rand_op(); b0 = rand_op(); end
                    else req0 = 1'b0;
                end else if (r0_granted) begin
                    if ($urandom_range(0, 1) == 0) begin a0 = rand_op(); b0 = rand_op(); end
                end else if ($urandom_range(0, 15) == 0) begin
                    req0 = 1'b0;
                end
            end
            if (!req1) begin
                if ($urandom_range(0, 3) == 0) begin
                    req1 = 1'b1; a1 = rand_op(); b1 = rand_op(); r1_granted = 1'b0;
                end
            end else begin
                if (gnt1) r1_granted = 1'b1;
                if (done1) begin
                    r1_granted = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin a1 = rand_op(); b1 = rand_op(); end
                    else req1 = 1'b0;
                end else if (r1_granted) begin
                    if ($urandom_range(0, 1) == 0) begin a1 = rand_op(); b1 = rand_op(); end
                end else if ($urandom_range(0, 15) == 0) begin
                    req1 = 1'b0;
                end
            end
        end
    end

    // ---------------- directed + random sequence on the main instance ----------------
    task automatic main_seq();
        int k;
        int who;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt0", W'(gnt0), '0);
        chk("rst_gnt1", W'(gnt1), '0);
        chk("rst_done0", W'(done0), '0);
        chk("rst_done1", W'(done1), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_result", result, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        #2 rst_n = 1'b1;

        // single op 7*9
        @(negedge clk);
        a0 = 7; b0 = 9; req0 = 1'b1;
        wait_for(0, 4, k);
        chk("t1_gnt_lat", W'(k), 1);
        chk("t1_busy", W'(busy), 1);
        chk("t1_mul_a", mul_a, 7);
        wait_for(2, 8, k);
        chk("t1_done_lat", W'(k), 2);
        chk("t1_result", result, 63);
        chk("t1_busy_done", W'(busy), 1);
        req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t1_busy_low", W'(busy), 0);
        chk("t1_done_low", W'(done0), 0);

        // negative operand on requester 1
        a1 = 5; b1 = 64'hFFFF_FFFF_FFFF_FFFB; req1 = 1'b1;
        wait_for(1, 4, k);
        chk("t2_gnt_lat", W'(k), 1);
        wait_for(3, 8, k);
        chk("t2_result", result, 64'hFFFF_FFFF_FFFF_FFE7);
        req1 = 1'b0;
        @(posedge clk); @(negedge clk);

        // simultaneous requests after reset
        do_reset();
        a0 = 3; b0 = 4; a1 = 6; b1 = 6; req0 = 1'b1; req1 = 1'b1;
        wait_for(0, 4, k);
        chk("t3_first_gnt0", W'(k), 1);
        chk("t3_no_gnt1", W'(gnt1), 0);
        wait_for(2, 8, k);
        chk("t3_result0", result, 12);
        req0 = 1'b0;
        wait_for(1, 8, k);
        chk("t3_gnt1_gap", W'(k), 2);
        wait_for(3, 8, k);
        chk("t3_result1", result, 36);
        req1 = 1'b0;
        @(posedge clk); @(negedge clk);

        // fairness with both held continuously
        do_reset();
        a0 = 11; b0 = 13; a1 = 17; b1 = 19; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_for(4, 8, k);
            who = gnt1 ? 1 : 0;
            chk("t4_order", W'(who), W'(i % 2));
            if (i > 0) chk("t4_gap", W'(k), 2);
            wait_for(who == 1 ? 3 : 2, 8, k);
            chk("t4_result", result, who == 1 ? W'(323) : W'(143));
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // reset while waiting
        do_reset();
        a0 = 3; b0 = 5; req0 = 1'b1;
        wait_for(0, 4, k);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", W'(busy), 0);
        chk("t5_rst_gnt0", W'(gnt0), 0);
        chk("t5_rst_done0", W'(done0), 0);
        chk("t5_rst_mul_a", mul_a, 0);
        chk("t5_rst_mul_b", mul_b, 0);
        chk("t5_rst_result", result, 0);
        a1 = 2; b1 = 9; req1 = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_for(4, 4, k);
        chk("t5_both_first0", W'(gnt1 ? 1 : 0), 0);
        chk("t5_both_lat", W'(k), 1);
        wait_for(2, 8, k);
        chk("t5_result0", result, 15);
        req0 = 1'b0;
        wait_for(1, 8, k);
        wait_for(3, 8, k);
        chk("t5_result1", result, 18);
        req1 = 1'b0;
        do_reset();
        req1 = 1'b1;
        wait_for(4, 4, k);
        chk("t5_only1", W'(gnt1 ? 1 : 0), 1);
        wait_for(3, 8, k);
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // randomized traffic
        rand_phase = 1'b1;
        repeat (3000) @(negedge clk);
        rand_phase = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // ---------------- settle-time-3 sweep ----------------
    task automatic sweep3();
        int k;
        repeat (2) @(negedge clk);
        #2 rst3_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            sa0 = W'(i); sb0 = W'(i); sreq0 = 1'b1;
            k = 0;
            for (int j = 1; j <= 10; j++) begin
                @(posedge clk);
                @(negedge clk);
                if (done0_3) begin
                    k = j;
                    break;
                end
            end
            chk("t6_latency", W'(k), 4);
            chk("t6_result", result_3, W'(i * i));
            sreq0 = 1'b0;
        end
    endtask

    initial begin
        fork
            main_seq();
            sweep3();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one combinational 64-bit multiplier (Thirty_Two_Bit_Multiplier style: a, b -> product) between two requesters, e.g. the MUL execute path and a MADD/address helper in the LEGv8 core.
- Registers the granted operands onto the multiplier inputs.
- Waits a programmable settle time.
- Captures the product and returns it with a one-cycle done pulse to the winning requester.

Parameters:
WIDTH, 64, operand and product width (product = low WIDTH bits of a*b).
SETTLE_CYCLES, 2, clock edges operands are held on the multiplier before product is sampled; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0  in  1  requester 0 request, level; held until done0.
a0  in  WIDTH  requester 0 operand a.
b0  in  WIDTH  requester 0 operand b.
req1  in  1  requester 1 request, level.
a1  in  WIDTH  requester 1 operand a.
b1  in  WIDTH  requester 1 operand b.
gnt0  out  1  one-cycle pulse: requester 0 operands latched.
gnt1  out  1  one-cycle pulse: requester 1 operands latched.
done0  out  1  one-cycle pulse: result valid for requester 0.
done1  out  1  one-cycle pulse: result valid for requester 1.
result  out  WIDTH  captured product, held until next done.
busy  out  1  high while an operation is in flight.
mul_a  out  WIDTH  registered operand to multiplier a.
mul_b  out  WIDTH  registered operand to multiplier b.
mul_product  in  WIDTH  multiplier product (combinational).

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. All outputs registered.
- Reset values: gnt0/1=0, done0/1=0, result=0, busy=0, mul_a=mul_b=0. State=IDLE, cnt=0, rr_ptr=0 (requester 0 favoured).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req0|req1 at an edge, select winner:
    - Only one requester asserted -> that requester.
    - Both asserted -> requester != rr_ptr_last_served; after reset, requester 0.
  - On that edge: mul_a/mul_b <= winner operands, gnt_winner<=1, busy<=1, cnt<=SETTLE_CYCLES, state<=WAIT.
  - Otherwise hold: mul_a/mul_b keep last values.
- WAIT:
  - gnt cleared after one cycle; cnt decrements each edge.
  - When cnt==1: result<=mul_product, done_winner<=1, last_served<=winner, state<=DONE.
- DONE (turnaround):
  - done cleared; busy<=0; state<=IDLE. Lets the requester drop req.
  - req still sampled high in DONE is ignored; it is re-evaluated in IDLE.
- Latency: req sampled at edge E -> gnt visible after E, done visible after edge E+SETTLE_CYCLES. Next grant no earlier than edge E+SETTLE_CYCLES+2. Throughput one op per SETTLE_CYCLES+2 cycles.
- Requester contract: operands stable from req rise until gnt; may change after gnt. req must fall the cycle after done unless a new op is wanted.
- Arithmetic: result is the multiplier's product unmodified (two's-complement wrap modulo 2^WIDTH). The controller does no sign handling.
- Fairness: with both reqs held continuously, grants strictly alternate 0,1,0,1...
- A req dropped before its grant is never served and never sees done.
- Reset mid-operation (any state): immediate return to reset values, no done issued, rr_ptr back to 0.
- gnt0&gnt1 and done0&done1 are never simultaneously high.

Test Plan:
1. Single op, SETTLE_CYCLES=2: req0 with a0=7, b0=9 sampled at edge 1 -> gnt0 after edge 1; done0 after edge 3 with result=63. busy high edges 1-3, low after edge 4.
2. Negative operand: req1 with a1=5, b1=0xFFFFFFFFFFFFFFFB -> done1 with result=0xFFFFFFFFFFFFFFE7 (-25).
3. Simultaneous after reset: req0 (3*4) and req1 (6*6) both held -> done0 result=12 first. Then done1 result=36; second gnt at edge 5.
4. Fairness: both reqs held for 6 ops -> grant order 0,1,0,1,0,1. No done0/done1 overlap; result matches each pair.
5. Reset mid-WAIT: rst_n low one cycle after gnt0 -> all outputs 0 immediately, no done0. After release, a held req1 is served first only if req0 absent; with both held, 0 is served first.
6. SETTLE_CYCLES=3, sweep i=0..999 with a0=b0=i -> each done0 arrives 3 edges after its sample, result=i*i.
